// File: rtl/instruction_fetcher.sv
// In-order front end: fetches one instruction at a time, applies static next-PC
// prediction and issues the decoded result to the RoB plus RS or LSB.
module instruction_fetcher #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,

    output logic        icache_req,
    output logic [31:0] icache_addr,
    input  logic        icache_valid,
    input  logic [31:0] icache_inst,

    output logic [31:0] dec_inst,
    input  logic [6:0]  dec_opcode,
    input  logic [5:0]  dec_rs1,
    input  logic [5:0]  dec_rs2,
    input  logic [5:0]  dec_rd,
    input  logic [31:0] dec_imm,

    input  logic        rob_full,
    input  logic        rs_full,
    input  logic        lsb_full,

    output logic        issue_valid,
    output logic        issue_to_lsb,
    output logic [6:0]  issue_opcode,
    output logic [5:0]  issue_rs1,
    output logic [5:0]  issue_rs2,
    output logic [5:0]  issue_rd,
    output logic [31:0] issue_imm,
    output logic [31:0] issue_pc,
    output logic        issue_pred_taken,

    input  logic        jalr_resolved,
    input  logic [31:0] jalr_target,

    input  logic        flush_in,
    input  logic [31:0] flush_pc
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        WAIT_JALR,
        HALT
    } state_e;

    localparam logic [6:0] OP_ILLEGAL = 7'd0;
    localparam logic [6:0] OP_JAL     = 7'd3;
    localparam logic [6:0] OP_JALR    = 7'd4;
    localparam logic [6:0] OP_BR_LO   = 7'd5;
    localparam logic [6:0] OP_BR_HI   = 7'd10;
    localparam logic [6:0] OP_LS_LO   = 7'd11;
    localparam logic [6:0] OP_LS_HI   = 7'd18;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        issueValid_q, issueValid_d;
    logic        issueToLsb_q, issueToLsb_d;
    logic [6:0]  issueOpcode_q, issueOpcode_d;
    logic [5:0]  issueRs1_q, issueRs1_d;
    logic [5:0]  issueRs2_q, issueRs2_d;
    logic [5:0]  issueRd_q, issueRd_d;
    logic [31:0] issueImm_q, issueImm_d;
    logic [31:0] issuePc_q, issuePc_d;
    logic        issuePred_q, issuePred_d;

    logic        isJal, isJalr, isBranch, toLsb, predTaken, stall;
    logic [31:0] nextPc;

    // Static prediction: jal and backward branches are taken; jalr waits for resolution.
    always_comb begin
        isJal     = (dec_opcode == OP_JAL);
        isJalr    = (dec_opcode == OP_JALR);
        isBranch  = (dec_opcode >= OP_BR_LO) && (dec_opcode <= OP_BR_HI);
        toLsb     = (dec_opcode >= OP_LS_LO) && (dec_opcode <= OP_LS_HI);
        predTaken = isJal | (isBranch & dec_imm[31]);
        stall     = rob_full | (toLsb ? lsb_full : rs_full);
        if (predTaken) begin
            nextPc = pc_q + dec_imm;
        end else if (isJalr) begin
            nextPc = pc_q;
        end else begin
            nextPc = pc_q + 32'd4;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inst_d        = inst_q;
        issueValid_d  = issueValid_q;
        issueToLsb_d  = issueToLsb_q;
        issueOpcode_d = issueOpcode_q;
        issueRs1_d    = issueRs1_q;
        issueRs2_d    = issueRs2_q;
        issueRd_d     = issueRd_q;
        issueImm_d    = issueImm_q;
        issuePc_d     = issuePc_q;
        issuePred_d   = issuePred_q;

        if (rdy_in) begin
            issueValid_d = 1'b0;
            if (flush_in) begin
                pc_d    = flush_pc;
                state_d = IDLE;
            end else begin
                case (state_q)
                    IDLE: state_d = FETCH;
                    FETCH: begin
                        if (icache_valid) begin
                            inst_d  = icache_inst;
                            state_d = ISSUE;
                        end
                    end
                    ISSUE: begin
                        if (dec_opcode == OP_ILLEGAL) begin
                            state_d = HALT;
                        end else if (!stall) begin
                            issueValid_d  = 1'b1;
                            issueToLsb_d  = toLsb;
                            issueOpcode_d = dec_opcode;
                            issueRs1_d    = dec_rs1;
                            issueRs2_d    = dec_rs2;
                            issueRd_d     = dec_rd;
                            issueImm_d    = dec_imm;
                            issuePc_d     = pc_q;
                            issuePred_d   = predTaken;
                            pc_d          = nextPc;
                            state_d       = isJalr ? WAIT_JALR : FETCH;
                        end
                    end
                    WAIT_JALR: begin
                        if (jalr_resolved) begin
                            pc_d    = jalr_target;
                            state_d = FETCH;
                        end
                    end
                    HALT:    state_d = HALT;
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            inst_q        <= 32'h0;
            issueValid_q  <= 1'b0;
            issueToLsb_q  <= 1'b0;
            issueOpcode_q <= 7'h0;
            issueRs1_q    <= 6'h0;
            issueRs2_q    <= 6'h0;
            issueRd_q     <= 6'h0;
            issueImm_q    <= 32'h0;
            issuePc_q     <= 32'h0;
            issuePred_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inst_q        <= inst_d;
            issueValid_q  <= issueValid_d;
            issueToLsb_q  <= issueToLsb_d;
            issueOpcode_q <= issueOpcode_d;
            issueRs1_q    <= issueRs1_d;
            issueRs2_q    <= issueRs2_d;
            issueRd_q     <= issueRd_d;
            issueImm_q    <= issueImm_d;
            issuePc_q     <= issuePc_d;
            issuePred_q   <= issuePred_d;
        end
    end

    assign icache_req       = (state_q == FETCH);
    assign icache_addr      = pc_q;
    assign dec_inst         = inst_q;
    assign issue_valid      = issueValid_q;
    assign issue_to_lsb     = issueToLsb_q;
    assign issue_opcode     = issueOpcode_q;
    assign issue_rs1        = issueRs1_q;
    assign issue_rs2        = issueRs2_q;
    assign issue_rd         = issueRd_q;
    assign issue_imm        = issueImm_q;
    assign issue_pc         = issuePc_q;
    assign issue_pred_taken = issuePred_q;

endmodule

// File: tb/tb_instruction_fetcher.sv
// Directed bench for instruction_fetcher; the bench plays both the icache and the decoder.
module tb_instruction_fetcher;

    logic        clk = 1'b0;
    logic        rstN, rdy;
    logic        icacheReq, icacheValid;
    logic [31:0] icacheAddr, icacheInst, decInst;
    logic [6:0]  decOpcode;
    logic [5:0]  decRs1, decRs2, decRd;
    logic [31:0] decImm;
    logic        robFull, rsFull, lsbFull;
    logic        issueValid, issueToLsb, issuePred;
    logic [6:0]  issueOpcode;
    logic [5:0]  issueRs1, issueRs2, issueRd;
    logic [31:0] issueImm, issuePc;
    logic        jalrResolved, flushIn;
    logic [31:0] jalrTarget, flushPc;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instruction_fetcher #(.RESET_PC(32'h0)) dut (
        .clk_in(clk), .rst_in(rstN), .rdy_in(rdy),
        .icache_req(icacheReq), .icache_addr(icacheAddr),
        .icache_valid(icacheValid), .icache_inst(icacheInst),
        .dec_inst(decInst), .dec_opcode(decOpcode),
        .dec_rs1(decRs1), .dec_rs2(decRs2), .dec_rd(decRd), .dec_imm(decImm),
        .rob_full(robFull), .rs_full(rsFull), .lsb_full(lsbFull),
        .issue_valid(issueValid), .issue_to_lsb(issueToLsb),
        .issue_opcode(issueOpcode), .issue_rs1(issueRs1), .issue_rs2(issueRs2),
        .issue_rd(issueRd), .issue_imm(issueImm), .issue_pc(issuePc),
        .issue_pred_taken(issuePred),
        .jalr_resolved(jalrResolved), .jalr_target(jalrTarget),
        .flush_in(flushIn), .flush_pc(flushPc)
    );

    typedef struct {
        string       name;
        logic [31:0] startPc;
        logic [31:0] inst;
        logic [6:0]  op;
        logic [31:0] imm;
        logic [5:0]  rs1;
        logic [5:0]  rs2;
        logic [5:0]  rd;
        logic [2:0]  fullMask;
        int          stallCycles;
        logic        expLsb;
        logic        expPred;
        logic [31:0] expNext;
    } vec_t;

    vec_t vecs[11];
    vec_t firstVec, jalrVec;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic waitReq(input string name);
        bit got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (icacheReq) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput({name, ".reqSeen"}, 32'(got), 32'd1);
    endtask

    task automatic flushTo(input logic [31:0] pc);
        flushIn = 1'b1;
        flushPc = pc;
        @(negedge clk);
        flushIn = 1'b0;
        checkOutput("flush.idleNoReq", 32'(icacheReq), 32'd0);
    endtask

    task automatic applyStimulus(input vec_t v, input bit doFlush, input int delay);
        if (doFlush) flushTo(v.startPc);
        waitReq(v.name);
        checkOutput({v.name, ".addr"}, icacheAddr, v.startPc);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            checkOutput({v.name, ".reqHold"}, {31'b0, icacheReq}, 32'd1);
            checkOutput({v.name, ".addrHold"}, icacheAddr, v.startPc);
        end
        decOpcode   = v.op;
        decImm      = v.imm;
        decRs1      = v.rs1;
        decRs2      = v.rs2;
        decRd       = v.rd;
        robFull     = v.fullMask[2];
        rsFull      = v.fullMask[1];
        lsbFull     = v.fullMask[0];
        icacheInst  = v.inst;
        icacheValid = 1'b1;
        @(negedge clk);
        icacheValid = 1'b0;
        checkOutput({v.name, ".decInst"}, decInst, v.inst);
        checkOutput({v.name, ".noEarlyIssue"}, 32'(issueValid), 32'd0);
        for (int i = 0; i < v.stallCycles; i++) begin
            @(negedge clk);
            checkOutput({v.name, ".stallNoIssue"}, 32'(issueValid), 32'd0);
            checkOutput({v.name, ".stallNoReq"}, 32'(icacheReq), 32'd0);
        end
        if (v.stallCycles > 0) begin
            robFull = 1'b0;
            rsFull  = 1'b0;
            lsbFull = 1'b0;
        end
        @(negedge clk);
        robFull = 1'b0;
        rsFull  = 1'b0;
        lsbFull = 1'b0;
        checkOutput({v.name, ".issueValid"}, 32'(issueValid), 32'd1);
        checkOutput({v.name, ".opcode"}, 32'(issueOpcode), 32'(v.op));
        checkOutput({v.name, ".rs1"}, 32'(issueRs1), 32'(v.rs1));
        checkOutput({v.name, ".rs2"}, 32'(issueRs2), 32'(v.rs2));
        checkOutput({v.name, ".rd"}, 32'(issueRd), 32'(v.rd));
        checkOutput({v.name, ".imm"}, issueImm, v.imm);
        checkOutput({v.name, ".pc"}, issuePc, v.startPc);
        checkOutput({v.name, ".toLsb"}, 32'(issueToLsb), 32'(v.expLsb));
        checkOutput({v.name, ".pred"}, 32'(issuePred), 32'(v.expPred));
        if (v.op != 7'd4) begin
            checkOutput({v.name, ".nextReq"}, 32'(icacheReq), 32'd1);
            checkOutput({v.name, ".nextAddr"}, icacheAddr, v.expNext);
            @(negedge clk);
            checkOutput({v.name, ".pulseEnds"}, 32'(issueValid), 32'd0);
            checkOutput({v.name, ".pcOnce"}, icacheAddr, v.expNext);
        end
    endtask

    initial begin
        vecs[0]  = '{"beqBack",  32'h100,      32'hFE000CE3, 7'd5,  32'hFFFFFFF8, 6'h20, 6'h21, 6'h00, 3'b000, 0, 1'b0, 1'b1, 32'hF8};
        vecs[1]  = '{"beqFwd",   32'h100,      32'h00000863, 7'd5,  32'h10,       6'h20, 6'h21, 6'h00, 3'b000, 0, 1'b0, 1'b0, 32'h104};
        vecs[2]  = '{"jal",      32'h200,      32'h040000EF, 7'd3,  32'h40,       6'h00, 6'h00, 6'h21, 3'b000, 0, 1'b0, 1'b1, 32'h240};
        vecs[3]  = '{"lwRsFull", 32'h40,       32'h00812183, 7'd13, 32'h8,        6'h22, 6'h00, 6'h23, 3'b010, 0, 1'b1, 1'b0, 32'h44};
        vecs[4]  = '{"swStall",  32'h44,       32'h00312223, 7'd18, 32'h4,        6'h22, 6'h23, 6'h00, 3'b001, 4, 1'b1, 1'b0, 32'h48};
        vecs[5]  = '{"addiRob",  32'h48,       32'h00100093, 7'd19, 32'h1,        6'h20, 6'h00, 6'h21, 3'b100, 2, 1'b0, 1'b0, 32'h4C};
        vecs[6]  = '{"addiLsbF", 32'h4C,       32'h00200113, 7'd19, 32'h2,        6'h20, 6'h00, 6'h22, 3'b001, 0, 1'b0, 1'b0, 32'h50};
        vecs[7]  = '{"bgeuWrap", 32'h10,       32'hFE0070E3, 7'd10, 32'hFFFFFFE0, 6'h20, 6'h20, 6'h00, 3'b000, 0, 1'b0, 1'b1, 32'hFFFFFFF0};
        vecs[8]  = '{"addiWrap", 32'hFFFFFFFC, 32'h00000013, 7'd19, 32'h0,        6'h20, 6'h00, 6'h20, 3'b000, 0, 1'b0, 1'b0, 32'h0};
        vecs[9]  = '{"lui",      32'h20,       32'h123452B7, 7'd1,  32'h12345000, 6'h00, 6'h00, 6'h25, 3'b000, 0, 1'b0, 1'b0, 32'h24};
        vecs[10] = '{"addRs",    32'h24,       32'h002081B3, 7'd20, 32'h0,        6'h21, 6'h22, 6'h23, 3'b010, 2, 1'b0, 1'b0, 32'h28};
        firstVec = '{"addiReset", 32'h0,  32'h00500093, 7'd19, 32'h5, 6'h20, 6'h00, 6'h21, 3'b000, 0, 1'b0, 1'b0, 32'h4};
        jalrVec  = '{"jalr",      32'h300, 32'h000080E7, 7'd4,  32'h0, 6'h21, 6'h00, 6'h21, 3'b000, 0, 1'b0, 1'b0, 32'h300};

        rstN = 1'b0; rdy = 1'b1;
        icacheValid = 1'b0; icacheInst = 32'h0;
        decOpcode = 7'd0; decRs1 = 6'h0; decRs2 = 6'h0; decRd = 6'h0; decImm = 32'h0;
        robFull = 1'b0; rsFull = 1'b0; lsbFull = 1'b0;
        jalrResolved = 1'b0; jalrTarget = 32'h0; flushIn = 1'b0; flushPc = 32'h0;

        #2;
        checkOutput("reset.req", 32'(icacheReq), 32'd0);
        checkOutput("reset.addr", icacheAddr, 32'h0);
        checkOutput("reset.issueValid", 32'(issueValid), 32'd0);
        checkOutput("reset.decInst", decInst, 32'h0);
        @(negedge clk);
        rstN = 1'b1;

        applyStimulus(firstVec, 1'b0, 3);
        foreach (vecs[i]) applyStimulus(vecs[i], 1'b1, 0);

        // Global ready low freezes an issuable instruction.
        flushTo(32'h60);
        waitReq("rdyLow");
        checkOutput("rdyLow.addr", icacheAddr, 32'h60);
        decOpcode = 7'd19; decImm = 32'h1; decRs1 = 6'h20; decRs2 = 6'h0; decRd = 6'h22;
        icacheInst = 32'h00100113; icacheValid = 1'b1;
        @(negedge clk);
        icacheValid = 1'b0;
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("rdyLow.noIssue", 32'(issueValid), 32'd0);
            checkOutput("rdyLow.noReq", 32'(icacheReq), 32'd0);
        end
        rdy = 1'b1;
        @(negedge clk);
        checkOutput("rdyLow.issue", 32'(issueValid), 32'd1);
        checkOutput("rdyLow.issuePc", issuePc, 32'h60);
        checkOutput("rdyLow.nextAddr", icacheAddr, 32'h64);

        applyStimulus(jalrVec, 1'b1, 0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("jalr.waitNoReq", 32'(icacheReq), 32'd0);
            @(negedge clk);
        end
        jalrResolved = 1'b1; jalrTarget = 32'h1234;
        @(negedge clk);
        jalrResolved = 1'b0;
        checkOutput("jalr.resolvedReq", 32'(icacheReq), 32'd1);
        checkOutput("jalr.resolvedAddr", icacheAddr, 32'h1234);

        applyStimulus(jalrVec, 1'b1, 0);
        jalrResolved = 1'b1; jalrTarget = 32'h1234;
        flushIn = 1'b1; flushPc = 32'h500;
        @(negedge clk);
        jalrResolved = 1'b0; flushIn = 1'b0;
        checkOutput("jalrFlush.idle", 32'(icacheReq), 32'd0);
        @(negedge clk);
        checkOutput("jalrFlush.req", 32'(icacheReq), 32'd1);
        checkOutput("jalrFlush.addr", icacheAddr, 32'h500);

        // Flush coincident with the icache response drops the instruction.
        decOpcode = 7'd19; decImm = 32'h5; decRd = 6'h21;
        icacheInst = 32'h00500093; icacheValid = 1'b1;
        flushIn = 1'b1; flushPc = 32'h80;
        @(negedge clk);
        icacheValid = 1'b0; flushIn = 1'b0;
        checkOutput("flushValid.idle", 32'(icacheReq), 32'd0);
        checkOutput("flushValid.noIssue", 32'(issueValid), 32'd0);
        @(negedge clk);
        checkOutput("flushValid.noIssueLate", 32'(issueValid), 32'd0);
        checkOutput("flushValid.req", 32'(icacheReq), 32'd1);
        checkOutput("flushValid.addr", icacheAddr, 32'h80);

        decOpcode = 7'd0;
        icacheInst = 32'hFFFFFFFF; icacheValid = 1'b1;
        @(negedge clk);
        icacheValid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("illegal.noIssue", 32'(issueValid), 32'd0);
            checkOutput("illegal.noReq", 32'(icacheReq), 32'd0);
        end
        flushTo(32'h10);
        waitReq("halted");
        checkOutput("halted.resumeAddr", icacheAddr, 32'h10);

        // Asynchronous reset in the middle of a FETCH cycle.
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("asyncReset.req", 32'(icacheReq), 32'd0);
        checkOutput("asyncReset.addr", icacheAddr, 32'h0);
        checkOutput("asyncReset.decInst", decInst, 32'h0);
        checkOutput("asyncReset.opcode", 32'(issueOpcode), 32'd0);
        checkOutput("asyncReset.issuePc", issuePc, 32'h0);
        @(negedge clk);
        rstN = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
